// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one iteration per clock, WIDTH iterations.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [2:0] OpMultu = 3'b001;
   localparam logic [2:0] OpMult  = 3'b010;
   localparam logic [2:0] OpDivu  = 3'b011;
   localparam logic [2:0] OpDiv   = 3'b100;
   localparam logic [2:0] OpMthi  = 3'b101;
   localparam logic [2:0] OpMtlo  = 3'b110;

   typedef enum logic {StIdle, StRun} state_e;

   state_e             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_div, r_neg_q, r_neg_r, r_div0, r_done;
   logic [WIDTH-1:0]   r_m;        // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   r_acc_hi;   // product upper half / partial remainder
   logic [WIDTH-1:0]   r_acc_lo;   // multiplier bits / dividend-quotient bits
   logic [WIDTH-1:0]   r_a_raw;    // dividend as latched, returned on divide by zero
   logic [WIDTH-1:0]   r_hi, r_lo;

   logic               w_accept, w_signed, w_a_neg, w_b_neg, w_last, w_is_div_op;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag;
   logic [WIDTH:0]     w_sum, w_shift, w_diff;
   logic [WIDTH-1:0]   w_hi_nx, w_lo_nx, w_res_hi, w_res_lo;
   logic [2*WIDTH-1:0] w_prod, w_prod_fix;

   assign w_accept    = (r_state == StIdle) && i_start && (i_op >= OpMultu) && (i_op <= OpDiv);
   assign w_is_div_op = (i_op == OpDivu) || (i_op == OpDiv);
   assign w_signed    = (i_op == OpMult) || (i_op == OpDiv);
   assign w_a_neg     = w_signed & i_a[WIDTH-1];
   assign w_b_neg     = w_signed & i_b[WIDTH-1];
   // Magnitude of the most negative value wraps to itself, read as unsigned.
   assign w_a_mag     = w_a_neg ? -i_a : i_a;
   assign w_b_mag     = w_b_neg ? -i_b : i_b;
   assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

   assign o_hi   = r_hi;
   assign o_lo   = r_lo;
   assign o_busy = (r_state == StRun);
   assign o_done = r_done;

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= StIdle;
      else       r_state <= w_state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_nxt = StRun;
         StRun:   if (w_last)   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // One multiply or divide iteration plus sign/divide-by-zero fix-up of the final result.
   always_comb begin
      w_sum   = {1'b0, r_acc_hi} + {1'b0, r_m};
      w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_m};
      if (r_is_div) begin
         // Restoring step: keep the difference only when it did not borrow.
         if (!w_diff[WIDTH]) begin
            w_hi_nx = w_diff[WIDTH-1:0];
            w_lo_nx = {r_acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            w_hi_nx = w_shift[WIDTH-1:0];
            w_lo_nx = {r_acc_lo[WIDTH-2:0], 1'b0};
         end
      end else if (r_acc_lo[0]) begin
         w_hi_nx = w_sum[WIDTH:1];
         w_lo_nx = {w_sum[0], r_acc_lo[WIDTH-1:1]};
      end else begin
         w_hi_nx = {1'b0, r_acc_hi[WIDTH-1:1]};
         w_lo_nx = {r_acc_hi[0], r_acc_lo[WIDTH-1:1]};
      end

      w_prod     = {w_hi_nx, w_lo_nx};
      w_prod_fix = r_neg_q ? -w_prod : w_prod;
      if (!r_is_div) begin
         w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
         w_res_lo = w_prod_fix[WIDTH-1:0];
      end else if (r_div0) begin
         w_res_hi = r_a_raw;
         w_res_lo = '1;
      end else begin
         w_res_hi = r_neg_r ? -w_hi_nx : w_hi_nx;
         w_res_lo = r_neg_q ? -w_lo_nx : w_lo_nx;
      end
   end

   // Datapath: operand capture, iteration, HI/LO writes and the done pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_done   <= 1'b0;
         r_m      <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_a_raw  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_state == StIdle) begin
            if (w_accept) begin
               r_cnt    <= '0;
               r_is_div <= w_is_div_op;
               r_neg_q  <= w_a_neg ^ w_b_neg;
               r_neg_r  <= w_a_neg;
               r_div0   <= (i_b == '0);
               r_a_raw  <= i_a;
               r_acc_hi <= '0;
               r_m      <= w_is_div_op ? w_b_mag : w_a_mag;
               r_acc_lo <= w_is_div_op ? w_a_mag : w_b_mag;
            end else if (i_start && (i_op == OpMthi)) begin
               r_hi <= i_a;
            end else if (i_start && (i_op == OpMtlo)) begin
               r_lo <= i_a;
            end
         end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_acc_hi <= w_hi_nx;
            r_acc_lo <= w_lo_nx;
            if (w_last) begin
               r_cnt  <= '0;
               r_hi   <= w_res_hi;
               r_lo   <= w_res_lo;
               r_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a result scoreboard.
module tb_muldiv_unit;

   localparam logic [2:0] OpMultu = 3'b001;
   localparam logic [2:0] OpMult  = 3'b010;
   localparam logic [2:0] OpDivu  = 3'b011;
   localparam logic [2:0] OpDiv   = 3'b100;
   localparam logic [2:0] OpMthi  = 3'b101;
   localparam logic [2:0] OpMtlo  = 3'b110;

   logic        i_clk, i_rst, i_start;
   logic [2:0]  i_op;
   logic [31:0] i_a, i_b;
   logic [31:0] o_hi, o_lo;
   logic        o_busy, o_done;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] sb_q[$];

   muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .i_op    (i_op),
      .i_a     (i_a),
      .i_b     (i_b),
      .o_hi    (o_hi),
      .o_lo    (o_lo),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference results computed with plain 64-bit arithmetic, {hi, lo}.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb, sp;
      logic [63:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      r  = '0;
      case (op)
         OpMultu: r = {32'b0, a} * {32'b0, b};
         OpMult: begin
            sp = sa * sb;
            r  = sp;
         end
         OpDivu: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
         OpDiv: begin
            if (b == 0) r = {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
            else r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Drive one start request; returns at the sample point just after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [63:0] exp);
      @(negedge i_clk);
      i_start = 1'b1;
      i_op    = op;
      i_a     = a;
      i_b     = b;
      if (push) sb_q.push_back(exp);
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_op    = 3'b000;
      i_a     = $urandom;
      i_b     = $urandom;
   endtask

   // Wait for done, checking latency and busy, then compare against the scoreboard head.
   task automatic wait_done(input string tag, input int exp_lat);
      int n = 0;
      int gaps = 0;
      bit seen = 0;
      logic [63:0] exp;
      for (int i = 0; i < exp_lat + 8; i++) begin
         @(posedge i_clk);
         #1;
         n++;
         if (o_done === 1'b1) begin
            seen = 1;
            break;
         end
         if (o_busy !== 1'b1) gaps++;
      end
      check({tag, "_seen"}, 64'(seen), 64'd1);
      check({tag, "_lat"}, 64'(n), 64'(exp_lat));
      check({tag, "_busy_run"}, 64'(gaps), 64'd0);
      check({tag, "_busy_done"}, 64'(o_busy), 64'd0);
      if (seen && sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         check({tag, "_hi"}, 64'(o_hi), 64'(exp[63:32]));
         check({tag, "_lo"}, 64'(o_lo), 64'(exp[31:0]));
      end else begin
         check({tag, "_result_available"}, 64'(sb_q.size()), 64'd1);
      end
   endtask

   initial begin
      int ndone;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      i_rst = 1'b1; i_start = 1'b0; i_op = 3'b000; i_a = '0; i_b = '0;
      #12;
      check("rst_hi", 64'(o_hi), 64'd0);
      check("rst_lo", 64'(o_lo), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // 1: unsigned max x max
      issue(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, {32'hFFFFFFFE, 32'h00000001});
      check("multu_busy_accept", 64'(o_busy), 64'd1);
      wait_done("multu_ff", 32);
      @(posedge i_clk); #1;
      check("multu_done_1cyc", 64'(o_done), 64'd0);

      // 2: signed multiply and divide
      issue(OpMult, 32'hFFFFFFFD, 32'h00000005, 1, {32'hFFFFFFFF, 32'hFFFFFFF1});
      wait_done("mult_neg", 32);
      issue(OpDiv, 32'hFFFFFFF9, 32'h00000002, 1, {32'hFFFFFFFF, 32'hFFFFFFFD});
      wait_done("div_neg", 32);

      // 3: divide by zero and the overflow case
      issue(OpDivu, 32'h00000064, 32'h0, 1, {32'h00000064, 32'hFFFFFFFF});
      wait_done("divu_zero", 32);
      issue(OpDiv, 32'h80000000, 32'hFFFFFFFF, 1, {32'h00000000, 32'h80000000});
      wait_done("div_ovf", 32);
      issue(OpMult, 32'h80000000, 32'h00000002, 1, {32'hFFFFFFFF, 32'h00000000});
      wait_done("mult_min", 32);
      issue(OpDiv, 32'h80000000, 32'h00000003, 1, model(OpDiv, 32'h80000000, 32'h3));
      wait_done("div_min", 32);

      // Random operations against the arithmetic model.
      for (int k = 0; k < 6; k++) begin
         rop = 3'($urandom_range(1, 4));
         ra  = $urandom;
         rb  = (k == 5) ? 32'h0 : $urandom;
         issue(rop, ra, rb, 1, model(rop, ra, rb));
         wait_done("rand", 32);
      end

      // 4: starts during RUN are ignored; MTLO in the done cycle
      issue(OpMthi, 32'h0, 32'h0, 0, 64'h0);
      issue(OpMultu, 32'h7, 32'h6, 1, {32'h0, 32'h0000002A});
      repeat (9) begin @(posedge i_clk); #1; end
      issue(OpMthi, 32'h12345678, 32'h0, 0, 64'h0);
      check("run_mthi_ignored", 64'(o_hi), 64'd0);
      issue(OpDivu, 32'h100, 32'h3, 0, 64'h0);
      wait_done("multu_76", 21);
      i_start = 1'b1; i_op = OpMtlo; i_a = 32'hCAFEBABE;
      @(posedge i_clk); #1;
      i_start = 1'b0; i_op = 3'b000;
      check("mtlo_lo", 64'(o_lo), 64'hCAFEBABE);
      check("mtlo_hi", 64'(o_hi), 64'd0);
      check("mtlo_busy", 64'(o_busy), 64'd0);
      check("mtlo_done", 64'(o_done), 64'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge i_clk); #1;
         if (o_done === 1'b1) ndone++;
      end
      check("no_stray_done", 64'(ndone), 64'd0);

      // 5: asynchronous reset mid-operation
      issue(OpDivu, 32'd1000, 32'd7, 0, 64'h0);
      repeat (15) begin @(posedge i_clk); #1; end
      check("abort_busy_before", 64'(o_busy), 64'd1);
      #2;
      i_rst = 1'b1;
      #1;
      check("abort_hi", 64'(o_hi), 64'd0);
      check("abort_lo", 64'(o_lo), 64'd0);
      check("abort_busy", 64'(o_busy), 64'd0);
      check("abort_done", 64'(o_done), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      check("abort_stays_idle", 64'(o_busy), 64'd0);
      issue(OpMultu, 32'd3, 32'd4, 1, {32'h0, 32'h0000000C});
      wait_done("multu_34", 32);

      // 6: back-to-back, second accepted in the done cycle
      issue(OpMultu, 32'd2, 32'd3, 1, {32'h0, 32'h6});
      wait_done("b2b_mul", 32);
      issue(OpDivu, 32'd9, 32'd2, 1, {32'h1, 32'h4});
      check("b2b_busy", 64'(o_busy), 64'd1);
      wait_done("b2b_div", 32);
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Takes the same A/B operands from the register-read stage.
- Computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers and services MTHI/MTLO.
- HI/LO feed the writeback mux for MFHI/MFLO. The busy output stalls issue while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; log2(WIDTH).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled on the rising edge.
- op  input  3  000 none, 001 MULTU, 010 MULT, 011 DIVU, 100 DIV, 101 MTHI, 110 MTLO, 111 none.
- A  input  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO data.
- B  input  WIDTH  operand B: multiplier or divisor.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  high while a mul/div is iterating.
- done  output  1  one-cycle pulse when HI/LO receive a mul/div result.

Behaviour:
- Reset, asynchronous, any time including mid-operation:
  - hi=0, lo=0, busy=0, done=0, counter=0, FSM=IDLE.
  - An in-flight operation is aborted and produces no result.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 with op in {001..100}: at that edge latch operands and sign info, set busy=1, go to RUN, counter=0.
  - start=1 with op=101: hi<=A at that edge; no busy, no done.
  - start=1 with op=110: lo<=B? No — lo<=A at that edge; no busy, no done.
  - op 000/111, or start=0: no effect.
- RUN:
  - One iteration per clock; counter increments each edge.
  - On the edge where counter==WIDTH-1: write hi/lo, busy<=0, done<=1 for exactly one cycle, go to IDLE.
- Latency: start accepted at edge N; busy high for exactly 32 cycles; hi/lo updated and done high after edge N+32.
- Back-to-back: a new start may be accepted in the cycle done is high (FSM is IDLE).
- start while busy: ignored for every op, including MTHI/MTLO. No queueing. hi/lo hold their old values throughout RUN.
- Multiply: shift-add over 32 iterations.
  - 64-bit product: hi = bits [63:32], lo = bits [31:0].
  - MULT (signed): multiply magnitudes, then negate the 64-bit product if the operand signs differ.
- Divide: restoring division over 32 iterations; lo = quotient, hi = remainder.
  - DIV (signed): divide magnitudes.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Boundary conditions:
  - Divide by zero (DIV or DIVU): still takes 32 cycles; result forced to hi=A as latched, lo=32'hFFFFFFFF; done pulses normally.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, no exception.
  - MULT/DIV with A or B = 0x80000000: magnitude is 0x80000000 treated as unsigned 32-bit; no overflow into the sign path.
- Operands are latched at acceptance. A and B may change freely during RUN without affecting the result.
- done is never high while busy is high. done is never asserted for MTHI/MTLO.

Test Plan:
1. Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF → busy high for 32 cycles; done pulses one cycle; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT A=0xFFFFFFFD (-3) B=0x00000005 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV A=0xFFFFFFF9 (-7) B=0x00000002 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU A=0x00000064 B=0 → after 32 cycles hi=0x00000064, lo=0xFFFFFFFF, done=1. Then DIV A=0x80000000 B=0xFFFFFFFF → lo=0x80000000, hi=0.
4. MULTU 7×6 started; at cycle 10 issue MTHI A=0x12345678 and a DIVU start → both ignored; final hi=0, lo=0x0000002A. In the done cycle issue MTLO A=0xCAFEBABE → lo=0xCAFEBABE next cycle, busy stays 0, no done.
5. DIVU 1000/7 started; assert rst asynchronously mid-cycle at iteration 15 → hi, lo, busy, done go to 0 immediately with no clock edge. After release, MULTU 3×4 → lo=0x0000000C exactly 32 cycles after acceptance.
6. Back-to-back: MULTU 2×3, then DIVU 9/2 accepted in the done cycle → lo=6 first; then lo=4, hi=1, with the second done exactly 33 edges after the first acceptance plus 32.
